// File: rtl/key_pkg.sv
// Shared types for the key debouncer: FSM state encoding and a small decode helper.
package key_pkg;

    typedef enum logic [1:0] {
        S_IDLE         = 2'd0,
        S_PRESS_WAIT   = 2'd1,
        S_PRESSED      = 2'd2,
        S_RELEASE_WAIT = 2'd3
    } key_fsm_e;

    // Debounced level implied by a state: the key counts as pressed until a release is accepted.
    function automatic logic state_is_pressed(input key_fsm_e st);
        return (st == S_PRESSED) || (st == S_RELEASE_WAIT);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit, with a configurable reset value.
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    // Next-state: plain shift through the two stages.
    always_comb begin
        meta_d = d_i;
        sync_d = meta_q;
    end

    // Synchronizer stages.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/key_debounce.sv
// Push-button debouncer: accepts a new key level only after it has been stable for
// STABLE_TICKS rising edges of div_clk, which is sampled as data in the orgin_clk domain.
module key_debounce
    import key_pkg::*;
#(
    parameter int unsigned STABLE_TICKS = 4,
    parameter logic        PRESS_LEVEL  = 1'b0
) (
    input  logic orgin_clk,
    input  logic reset_n,
    input  logic div_clk,
    input  logic key_in,
    output logic key_state,
    output logic key_press,
    output logic key_release
);

    localparam int unsigned     CntW    = $clog2(STABLE_TICKS + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(STABLE_TICKS - 1);

    logic            key_sync;
    logic            div_sync;
    logic            key_act;
    logic            tick;
    logic            div_hist_q, div_hist_d;
    key_fsm_e        state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            key_state_q, key_state_d;
    logic            press_q, press_d;
    logic            release_q, release_d;

    // Synchronizers reset to the released level so reset never looks like a press.
    sync_2ff #(
        .RST_VAL(~PRESS_LEVEL)
    ) u_key_sync (
        .clk_i (orgin_clk),
        .rst_ni(reset_n),
        .d_i   (key_in),
        .q_o   (key_sync)
    );

    sync_2ff #(
        .RST_VAL(1'b0)
    ) u_div_sync (
        .clk_i (orgin_clk),
        .rst_ni(reset_n),
        .d_i   (div_clk),
        .q_o   (div_sync)
    );

    // Rising-edge detect on the synchronized divider output, plus level decode of the key.
    always_comb begin
        div_hist_d = div_sync;
        tick       = div_sync & ~div_hist_q;
        key_act    = (key_sync == PRESS_LEVEL);
    end

    // Next-state: a bounce always returns to the stable state and takes priority over a tick.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (key_act) begin
                    state_d = S_PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            S_PRESS_WAIT: begin
                if (!key_act) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (tick) begin
                    if (cnt_q == CntLast) begin
                        state_d = S_PRESSED;
                        cnt_d   = '0;
                        press_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
            end
            S_PRESSED: begin
                if (!key_act) begin
                    state_d = S_RELEASE_WAIT;
                    cnt_d   = '0;
                end
            end
            S_RELEASE_WAIT: begin
                if (key_act) begin
                    state_d = S_PRESSED;
                    cnt_d   = '0;
                end else if (tick) begin
                    if (cnt_q == CntLast) begin
                        state_d   = S_IDLE;
                        cnt_d     = '0;
                        release_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
        key_state_d = state_is_pressed(state_d);
    end

    // State, counter and registered outputs.
    always_ff @(posedge orgin_clk or negedge reset_n) begin
        if (!reset_n) begin
            div_hist_q  <= 1'b0;
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            key_state_q <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
        end else begin
            div_hist_q  <= div_hist_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            key_state_q <= key_state_d;
            press_q     <= press_d;
            release_q   <= release_d;
        end
    end

    assign key_state   = key_state_q;
    assign key_press   = press_q;
    assign key_release = release_q;

endmodule

// File: tb/tb_key_debounce.sv
// Self-checking bench for key_debounce: directed scenarios plus random key/div_clk activity,
// compared every cycle against a run-length reference model of the debounce rules.
module tb_key_debounce;

    localparam int unsigned StableTicks = 4;
    localparam logic        PressLevel  = 1'b0;

    logic orgin_clk = 1'b0;
    logic reset_n   = 1'b0;
    logic div_clk   = 1'b0;
    logic key_in    = 1'b1;
    logic key_state, key_press, key_release;

    key_debounce #(
        .STABLE_TICKS(StableTicks),
        .PRESS_LEVEL (PressLevel)
    ) dut (
        .orgin_clk  (orgin_clk),
        .reset_n    (reset_n),
        .div_clk    (div_clk),
        .key_in     (key_in),
        .key_state  (key_state),
        .key_press  (key_press),
        .key_release(key_release)
    );

    always #5 orgin_clk = ~orgin_clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: input histories, accepted level, length of the current disagreeing run
    // and ticks seen inside that run (the run's first cycle only notices the change).
    logic m_k1, m_k2, m_d1, m_d2, m_d3;
    logic m_level, m_press, m_rel;
    int   m_run, m_ticks;

    task automatic model_reset();
        m_k1 = ~PressLevel;
        m_k2 = ~PressLevel;
        m_d1 = 1'b0;
        m_d2 = 1'b0;
        m_d3 = 1'b0;
        m_level = 1'b0;
        m_press = 1'b0;
        m_rel   = 1'b0;
        m_run   = 0;
        m_ticks = 0;
    endtask

    task automatic model_step(input logic k, input logic d);
        logic act, tk;
        act = (m_k2 == PressLevel);
        tk  = m_d2 & ~m_d3;
        m_press = 1'b0;
        m_rel   = 1'b0;
        if (act == m_level) begin
            m_run   = 0;
            m_ticks = 0;
        end else if (m_run == 0) begin
            m_run   = 1;
            m_ticks = 0;
        end else if (tk) begin
            m_ticks++;
            if (m_ticks == int'(StableTicks)) begin
                m_level = ~m_level;
                if (m_level) m_press = 1'b1;
                else         m_rel   = 1'b1;
                m_run   = 0;
                m_ticks = 0;
            end
        end
        m_k2 = m_k1;
        m_k1 = k;
        m_d3 = m_d2;
        m_d2 = m_d1;
        m_d1 = d;
    endtask

    // div_clk source: toggles every 4 orgin_clk cycles while running, frozen otherwise.
    int   div_ctr = 0;
    logic div_val = 1'b0;
    bit   div_run = 1'b1;
    int   cyc = 0;
    int   n_press = 0;
    int   n_rel = 0;
    logic cur_key = 1'b1;

    function automatic logic div_peek();
        return (div_run && div_ctr == 3) ? ~div_val : div_val;
    endfunction

    task automatic cycle(input logic k);
        cur_key = k;
        key_in  = k;
        div_val = div_peek();
        if (div_run) div_ctr = (div_ctr == 3) ? 0 : div_ctr + 1;
        div_clk = div_val;
        @(posedge orgin_clk);
        cyc++;
        if (reset_n) model_step(k, div_val);
        else         model_reset();
        #1;
        if (key_press)   n_press++;
        if (key_release) n_rel++;
        check_eq("key_state", 32'(key_state), 32'(m_level));
        check_eq("key_press", 32'(key_press), 32'(m_press));
        check_eq("key_release", 32'(key_release), 32'(m_rel));
        check_eq("pulse_excl", 32'(key_press & key_release), 32'd0);
    endtask

    task automatic apply_reset(input int n, input logic k);
        reset_n = 1'b0;
        model_reset();
        #1;
        check_eq("rst_state", 32'(key_state), 32'd0);
        check_eq("rst_press", 32'(key_press), 32'd0);
        check_eq("rst_release", 32'(key_release), 32'd0);
        repeat (n) cycle(k);
        reset_n = 1'b1;
    endtask

    task automatic hold(input logic k, input int n);
        repeat (n) cycle(k);
    endtask

    initial begin
        int cyc0, lat, p0, r0;
        bit hit;
        model_reset();
        #3;

        // 1: reset with key pressed, then nothing before four fresh ticks
        apply_reset(5, 1'b0);
        hold(1'b0, 20);
        check_eq("no_early_press", 32'(n_press), 32'd0);
        hold(1'b0, 30);
        check_eq("press_after_reset", 32'(n_press), 32'd1);
        hold(1'b1, 50);
        check_eq("release_after_reset", 32'(n_rel), 32'd1);

        // 2: clean press; first counted tick lands 1..8 cycles after key_act settles (edge +2),
        // so the pulse is seen 27..34 edges after the edge that first samples the change
        p0 = n_press;
        cycle(1'b0);
        cyc0 = cyc;
        hit  = 1'b0;
        for (int i = 0; i < 60 && !hit; i++) begin
            cycle(1'b0);
            if (key_press) hit = 1'b1;
        end
        lat = cyc - cyc0;
        check_eq("press_seen", 32'(hit), 32'd1);
        check_eq("press_lat_win", 32'(lat >= 27 && lat <= 34), 32'd1);
        check_eq("state_with_press", 32'(key_state), 32'd1);
        hold(1'b0, 5);
        r0 = n_rel;
        hold(1'b1, 50);
        check_eq("clean_release", 32'(n_rel - r0), 32'd1);

        // 3: press bounce, 5-cycle toggles
        p0 = n_press;
        for (int i = 0; i < 60; i++) cycle(((i / 5) % 2 == 0) ? 1'b0 : 1'b1);
        hold(1'b1, 40);
        check_eq("bounce_no_press", 32'(n_press - p0), 32'd0);
        check_eq("bounce_state", 32'(key_state), 32'd0);

        // 4: release glitch while pressed
        hold(1'b0, 45);
        r0 = n_rel;
        hold(1'b1, 10);
        hold(1'b0, 20);
        check_eq("glitch_no_release", 32'(n_rel - r0), 32'd0);
        check_eq("glitch_state", 32'(key_state), 32'd1);
        hold(1'b1, 50);

        // 5: key releases in the same cycle as the accepting tick
        p0  = n_press;
        hit = 1'b0;
        for (int i = 0; i < 100 && !hit; i++) begin
            if (m_run != 0 && m_ticks == 3 && !(m_d1 & ~m_d2) && div_peek() && !m_d1) hit = 1'b1;
            cycle(hit ? 1'b1 : 1'b0);
        end
        check_eq("tie_reached", 32'(hit), 32'd1);
        hold(1'b1, 40);
        check_eq("tie_no_press", 32'(n_press - p0), 32'd0);
        check_eq("tie_state", 32'(key_state), 32'd0);

        // 6: reset after three ticks of a press wait; press then needs four new ticks
        hit = 1'b0;
        for (int i = 0; i < 60 && !hit; i++) begin
            cycle(1'b0);
            if (m_ticks == 3) hit = 1'b1;
        end
        check_eq("midwait_reached", 32'(hit), 32'd1);
        apply_reset(3, 1'b0);
        cyc0 = cyc + 1;
        hit  = 1'b0;
        for (int i = 0; i < 60 && !hit; i++) begin
            cycle(1'b0);
            if (key_press) hit = 1'b1;
        end
        lat = cyc - cyc0;
        check_eq("midwait_press", 32'(hit), 32'd1);
        check_eq("midwait_lat_win", 32'(lat >= 27 && lat <= 34), 32'd1);
        hold(1'b1, 50);

        // Random activity: level runs with occasional bounces, stuck divider and resets
        for (int ep = 0; ep < 300; ep++) begin
            int r;
            r = $urandom_range(0, 11);
            if (r == 0) begin
                div_run = ~div_run;
            end else if (r == 1) begin
                apply_reset($urandom_range(1, 4), cur_key);
            end else begin
                logic lvl;
                int   n;
                lvl = 1'($urandom_range(0, 1));
                n   = $urandom_range(1, 45);
                for (int i = 0; i < n; i++) begin
                    if ($urandom_range(0, 15) == 0) cycle(~lvl);
                    else                            cycle(lvl);
                end
            end
        end
        div_run = 1'b1;
        hold(1'b1, 50);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timeout");
    end

endmodule
